// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Shares one SRAM-like memory port between the fetch-stage instruction
//   requester (I) and the memory-stage data requester (D). Data has fixed
//   priority. Once a request is presented and stalls, the grant is locked
//   until that request is accepted. An in-order tag FIFO of accepted requests
//   routes each response back to its owner. Instruction responses still in
//   flight can be discarded with inst_cancel.
//
// Ports
//   clk, rstn                 clock, synchronous active-low reset
//   inst_* / data_*           requester side: req, wr, size, wstrb, addr, wdata in;
//                             addr_ok, data_ok, rdata out
//   inst_cancel               pulse: drop all pending fetch responses
//   mem_*                     memory side: req and payload out;
//                             addr_ok, data_ok, rdata in
//   proto_err                 sticky: response arrived with no request outstanding
//
// Lock FSM
//   state   | meaning
//   LK_NONE | no stalled request, grant follows priority
//   LK_INST | fetch request presented but not accepted, grant held on I
//   LK_DATA | data request presented but not accepted, grant held on D

module mem_req_arbiter #(
  parameter int OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rstn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        inst_cancel,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic        proto_err
);

  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam logic [PW:0] DEPTH = (PW+1)'(OUTSTANDING);

  typedef enum logic [1:0] {
    LK_NONE = 2'd0,
    LK_INST = 2'd1,
    LK_DATA = 2'd2
  } lock_state_t;

  lock_state_t   lock_q, lock_d;
  logic          grant_d;          // 1 = data requester owns the port
  logic          any_req;
  logic          mem_fire;
  logic          pop;
  logic          head_id;
  logic          head_disc;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   count_q;
  logic          proto_err_q;

  // Tag FIFO: id (1 = data) and discard flag per accepted request.
  logic          fifo_id   [OUTSTANDING];
  logic          fifo_disc [OUTSTANDING];

  always_comb begin
    grant_d = data_req;
    case (lock_q)
      LK_INST: grant_d = 1'b0;
      LK_DATA: grant_d = 1'b1;
      default: grant_d = data_req;
    endcase
  end

  // Outputs are held quiet while reset is asserted so that nothing handshakes
  // before the tag FIFO is known to be empty.
  assign any_req  = (lock_q != LK_NONE) || data_req || inst_req;
  assign mem_req  = rstn && any_req && (count_q < DEPTH);
  assign mem_fire = mem_req && mem_addr_ok;

  assign mem_wr    = grant_d ? data_wr    : inst_wr;
  assign mem_size  = grant_d ? data_size  : inst_size;
  assign mem_wstrb = grant_d ? data_wstrb : inst_wstrb;
  assign mem_addr  = grant_d ? data_addr  : inst_addr;
  assign mem_wdata = grant_d ? data_wdata : inst_wdata;

  assign inst_addr_ok = mem_fire && !grant_d;
  assign data_addr_ok = mem_fire &&  grant_d;

  assign head_id   = fifo_id[rptr_q];
  assign head_disc = fifo_disc[rptr_q];
  assign pop       = rstn && mem_data_ok && (count_q != '0);

  // A discarded fetch entry is still popped, just without a data_ok.
  assign inst_data_ok = pop && !head_id && !head_disc;
  assign data_data_ok = pop &&  head_id;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign proto_err    = proto_err_q;

  always_ff @(posedge clk) begin
    if (!rstn) lock_q <= LK_NONE;
    else       lock_q <= lock_d;
  end

  always_comb begin
    lock_d = lock_q;
    if (mem_req) begin
      if (mem_addr_ok) lock_d = LK_NONE;
      else             lock_d = grant_d ? LK_DATA : LK_INST;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (mem_fire) wptr_q <= wptr_q + 1'b1;
      if (pop)      rptr_q <= rptr_q + 1'b1;
      case ({mem_fire, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (mem_data_ok && (count_q == '0)) proto_err_q <= 1'b1;
    end
  end

  // Cancel marks every fetch entry; slots outside the valid window are
  // rewritten on push, so marking them too is harmless. The push write comes
  // last so an entry accepted in the cancel cycle carries its own flag.
  always_ff @(posedge clk) begin
    if (inst_cancel) begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        if (!fifo_id[i]) fifo_disc[i] <= 1'b1;
      end
    end
    if (mem_fire) begin
      fifo_id[wptr_q]   <= grant_d;
      fifo_disc[wptr_q] <= !grant_d && inst_cancel;
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;

  localparam int DEPTH = 4;

  logic        clk, rstn;
  logic        inst_req, inst_wr, inst_cancel;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_addr_ok, mem_data_ok;
  logic        proto_err;

  mem_req_arbiter #(.OUTSTANDING(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata), .inst_cancel(inst_cancel),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of outstanding responses in acceptance order.
  typedef struct {
    bit is_data;
    bit discard;
  } ent_t;

  ent_t mq[$];
  bit   m_lock, m_lock_data, m_perr, m_iacc, m_dacc, seen_rst;
  int   n_tests, n_fail, cnt_idok, cnt_ddok;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    inst_req = 0; inst_wr = 0; inst_size = 2; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
    inst_cancel = 0;
    data_req = 0; data_wr = 0; data_size = 2; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  // One clock cycle: compare all outputs with the model, cross the edge,
  // advance the model. Entered and left just after a falling edge.
  task automatic tick();
    bit   g, mr, iok, dok, idok, ddok;
    ent_t e;
    #1;
    g    = m_lock ? m_lock_data : data_req;
    mr   = rstn && (m_lock || data_req || inst_req) && (mq.size() < DEPTH);
    iok  = mr && mem_addr_ok && !g;
    dok  = mr && mem_addr_ok && g;
    idok = 0;
    ddok = 0;
    if (rstn && mem_data_ok && mq.size() != 0) begin
      idok = !mq[0].is_data && !mq[0].discard;
      ddok = mq[0].is_data;
    end
    check_val("mem_req", mem_req, mr);
    check_val("inst_addr_ok", inst_addr_ok, iok);
    check_val("data_addr_ok", data_addr_ok, dok);
    check_val("inst_data_ok", inst_data_ok, idok);
    check_val("data_data_ok", data_data_ok, ddok);
    if (seen_rst) check_val("proto_err", proto_err, m_perr);
    if (mr) begin
      check_val("mem_ctrl", {mem_wr, mem_size, mem_wstrb, mem_addr},
                g ? {data_wr, data_size, data_wstrb, data_addr}
                  : {inst_wr, inst_size, inst_wstrb, inst_addr});
      check_val("mem_wdata", mem_wdata, g ? data_wdata : inst_wdata);
    end
    if (idok) check_val("inst_rdata", inst_rdata, mem_rdata);
    if (ddok) check_val("data_rdata", data_rdata, mem_rdata);
    cnt_idok += int'(inst_data_ok);
    cnt_ddok += int'(data_data_ok);
    m_iacc = iok;
    m_dacc = dok;
    @(posedge clk);
    if (!rstn) begin
      mq.delete();
      m_lock   = 0;
      m_perr   = 0;
      seen_rst = 1;
    end else begin
      if (mem_data_ok) begin
        if (mq.size() != 0) void'(mq.pop_front());
        else m_perr = 1;
      end
      if (inst_cancel) foreach (mq[i]) if (!mq[i].is_data) mq[i].discard = 1;
      if (mr && mem_addr_ok) begin
        e.is_data = g;
        e.discard = !g && inst_cancel;
        mq.push_back(e);
      end
      if (mr) begin
        if (mem_addr_ok) m_lock = 0;
        else begin
          m_lock      = 1;
          m_lock_data = g;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i0, d0;
    n_tests = 0; n_fail = 0; cnt_idok = 0; cnt_ddok = 0;
    m_lock = 0; m_lock_data = 0; m_perr = 0; seen_rst = 0;
    set_idle();
    rstn = 0;
    inst_req = 1; inst_addr = 32'h1c000000;
    @(negedge clk);

    // reset with a request held
    tick();
    tick();
    #1;
    check_val("rst_mem_req", mem_req, 0);
    check_val("rst_proto_err", proto_err, 0);

    // first fetch right after reset
    rstn = 1; mem_addr_ok = 1;
    #1;
    check_val("t1_iaok", inst_addr_ok, 1);
    check_val("t1_addr", mem_addr, 32'h1c000000);
    tick();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h12345678;
    tick();
    set_idle();

    // data beats instruction, responses routed in order
    data_req = 1; data_wr = 1; data_wstrb = 4'hf; data_addr = 32'h80000000; data_wdata = 32'hcafef00d;
    inst_req = 1; inst_addr = 32'h1c000008; mem_addr_ok = 1;
    #1;
    check_val("t2_daok", data_addr_ok, 1);
    check_val("t2_iaok0", inst_addr_ok, 0);
    tick();
    data_req = 0;
    #1;
    check_val("t2_iaok", inst_addr_ok, 1);
    tick();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hAAAA0000;
    #1;
    check_val("t2_ddok", data_data_ok, 1);
    check_val("t2_idok0", inst_data_ok, 0);
    check_val("t2_drdata", data_rdata, 32'hAAAA0000);
    tick();
    mem_rdata = 32'hBBBB0000;
    #1;
    check_val("t2_idok", inst_data_ok, 1);
    check_val("t2_ddok0", data_data_ok, 0);
    check_val("t2_irdata", inst_rdata, 32'hBBBB0000);
    tick();
    set_idle();

    // stalled fetch keeps the grant against a later data request
    inst_req = 1; inst_addr = 32'h1c000004;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin data_req = 1; data_addr = 32'h80000020; end
      #1;
      check_val("t3_mreq", mem_req, 1);
      check_val("t3_addr", mem_addr, 32'h1c000004);
      tick();
    end
    mem_addr_ok = 1;
    #1;
    check_val("t3_iaok", inst_addr_ok, 1);
    check_val("t3_daok0", data_addr_ok, 0);
    tick();
    inst_req = 0;
    #1;
    check_val("t3_daok", data_addr_ok, 1);
    tick();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    tick();
    tick();
    set_idle();

    // fill to the outstanding limit
    inst_req = 1; mem_addr_ok = 1;
    for (int k = 0; k < DEPTH; k++) begin
      inst_addr = 32'h1c000100 + 32'(4 * k);
      tick();
    end
    inst_addr = 32'h1c000200;
    #1;
    check_val("t4_full_mreq", mem_req, 0);
    tick();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h0badf00d;
    #1;
    check_val("t4_idok", inst_data_ok, 1);
    tick();
    mem_data_ok = 0;
    #1;
    check_val("t4_mreq_again", mem_req, 1);
    tick();
    mem_addr_ok = 1;
    tick();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    for (int k = 0; k < DEPTH; k++) tick();
    set_idle();

    // cancel drops every pending fetch response
    mem_addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      inst_req = (k != 2); inst_addr = 32'h1c000300 + 32'(4 * k);
      data_req = (k == 2); data_addr = 32'h80000100;
      tick();
    end
    inst_req = 0; data_req = 0; mem_addr_ok = 0; inst_cancel = 1;
    tick();
    inst_cancel = 0;
    i0 = cnt_idok; d0 = cnt_ddok;
    mem_data_ok = 1;
    for (int k = 0; k < 4; k++) tick();
    check_val("t5_inst_resp", 32'(cnt_idok - i0), 0);
    check_val("t5_data_resp", 32'(cnt_ddok - d0), 1);
    set_idle();

    // stray response with empty FIFO
    mem_data_ok = 1;
    #1;
    check_val("t6_idok", inst_data_ok, 0);
    check_val("t6_ddok", data_data_ok, 0);
    tick();
    mem_data_ok = 0;
    #1;
    check_val("t6_perr", proto_err, 1);
    tick(); tick(); tick();
    check_val("t6_perr_sticky", proto_err, 1);
    rstn = 0;
    tick();
    rstn = 1;
    #1;
    check_val("t6_perr_clr", proto_err, 0);
    tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (m_iacc) inst_req = 0;
      if (m_dacc) data_req = 0;
      if (!inst_req && $urandom_range(0, 2) == 0) begin
        inst_req   = 1;
        inst_addr  = $urandom & 32'hfffffffc;
        inst_wdata = $urandom;
        inst_wstrb = 4'($urandom);
      end
      if (!data_req && $urandom_range(0, 2) == 0) begin
        data_req   = 1;
        data_wr    = 1'($urandom);
        data_size  = 2'($urandom_range(0, 2));
        data_wstrb = 4'($urandom);
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
      mem_addr_ok = 1'($urandom);
      mem_data_ok = (mq.size() != 0) && ($urandom_range(0, 1) == 1);
      mem_rdata   = $urandom;
      inst_cancel = ($urandom_range(0, 15) == 0);
      rstn        = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares the single SRAM-like memory port between the fetch-stage instruction requester and the memory-stage data requester.
- Uses fixed priority (data over instruction) with a stable-grant lock while a request waits for acceptance.
- An in-order tag FIFO of up to OUTSTANDING accepted requests routes each response back to its owner.
- Instruction responses can be discarded on a pipeline flush (branch, exception, ertn) via inst_cancel.

Parameters:
OUTSTANDING, 4, max accepted-but-unanswered requests; power of two, 2..16.

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
inst_req  in  1  fetch request valid; held stable until inst_addr_ok
inst_wr  in  1  write flag (fetch drives 0)
inst_size  in  2  access size (0=byte, 1=half, 2=word)
inst_wstrb  in  4  byte strobes
inst_addr  in  32  physical address
inst_wdata  in  32  write data
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  fetch response valid this cycle
inst_rdata  out  32  fetch read data
inst_cancel  in  1  pulse: discard all fetch responses still pending
data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  data requester, same rules as inst_*
data_addr_ok  out  1  data request accepted
data_data_ok  out  1  data response valid
data_rdata  out  32  data read data
mem_req  out  1  request to memory
mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/2/4/32/32  muxed from granted requester
mem_addr_ok  in  1  memory accepts request (mem_req && mem_addr_ok = handshake)
mem_data_ok  in  1  memory returns response, strictly in acceptance order
mem_rdata  in  32  memory read data
proto_err  out  1  sticky: mem_data_ok seen with FIFO empty

Behaviour:
- Reset (rstn=0 at posedge): FIFO count=0, pointers=0, lock_valid=0, proto_err=0. Consequently mem_req, all addr_ok and all data_ok are 0 until the first request. Reset mid-transaction drops all pending tags; later stray mem_data_ok sets proto_err.
- Grant (combinational):
  - If lock_valid, grant=lock_id.
  - Else if data_req, grant=D.
  - Else if inst_req, grant=I.
- mem_req = (lock_valid || data_req || inst_req) && (count < OUTSTANDING).
- mem_* payload is muxed from the granted requester.
- Lock:
  - At posedge, if mem_req && !mem_addr_ok: lock_valid<=1, lock_id<=grant.
  - If mem_req && mem_addr_ok: lock_valid<=0.
  - A pending instruction request is never preempted by a later data_req while locked.
- Acceptance: inst_addr_ok = mem_req && mem_addr_ok && grant==I; data_addr_ok likewise for D. Zero-cycle pass-through.
- Push: on mem_req && mem_addr_ok, write {id=grant, discard=(grant==I && inst_cancel)} at wptr; wptr++ mod OUTSTANDING.
- Response routing (combinational, using head entry at rptr):
  - inst_data_ok = mem_data_ok && count!=0 && head.id==I && !head.discard.
  - data_data_ok = mem_data_ok && count!=0 && head.id==D.
  - inst_rdata = data_rdata = mem_rdata, unmasked.
- Pop: on mem_data_ok && count!=0, rptr++. A discarded head is popped silently with no data_ok asserted.
- Count: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop. Push is impossible at count==OUTSTANDING because mem_req is masked. Simultaneous push+pop at count==OUTSTANDING-1 leaves count unchanged.
- inst_cancel: at posedge, discard<=1 for every valid FIFO entry with id==I, including an entry pushed in the same cycle. It does not affect a locked, not-yet-accepted request; the fetch stage holds and re-presents that request itself. A head entry popped in the cancel cycle is already decided by its current discard bit.
- Empty response: mem_data_ok with count==0 sets proto_err<=1. No data_ok is asserted and count stays 0. proto_err clears only on reset.
- Latency: arbitration adds 0 cycles; response routing adds 0 cycles.

Test Plan:
- Reset with inst_req=1 held low-rstn -> mem_req=0, proto_err=0. First cycle after reset with mem_addr_ok=1 -> inst_addr_ok=1, mem_addr=inst_addr=0x1c000000.
- data_req and inst_req both asserted, mem_addr_ok=1 -> data_addr_ok=1, inst_addr_ok=0. Next cycle inst accepted. Two mem_data_ok with rdata 0xAAAA0000, 0xBBBB0000 -> data_data_ok then inst_data_ok, in that order.
- inst_req at 0x1c000004, mem_addr_ok=0 for 3 cycles, data_req rises in cycle 2 -> mem_addr stays 0x1c000004, mem_req stays 1. Inst accepted first, then data.
- 4 inst accepts with no response -> count=4, mem_req=0 while inst_req=1. One mem_data_ok -> inst_data_ok=1 and mem_req=1 again.
- 3 inst pending + 1 data pending (order I,I,D,I), inst_cancel pulse, 4 mem_data_ok -> only data_data_ok asserted once. inst_data_ok stays 0 throughout; count returns to 0.
- mem_data_ok with empty FIFO -> proto_err=1, no data_ok asserted, stays 1 until rstn=0.
